// File: rtl/audio_tone_seq.sv
// Purpose : pattern-driven tone generator feeding the PDM modulator (offset-binary, 0x8000 = silence).
// Latency : sample/sample_valid follow the internal sample strobe by exactly 2 clk cycles.
// Backpres: none; the sink must accept every sample_valid pulse, enable=0 freezes and mutes.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   enable            1 = run; 0 = hold all sequencing state and force silence
//   wave_sel[1:0]     00 square, 01 saw, 10 triangle, 11 noise (used at each strobe)
//   sample[15:0]      unsigned offset-binary sample
//   sample_valid      one-cycle pulse when sample is updated
//   step[3:0]         current sequencer step
//   note_on           current step plays a note (0 = rest)
module audio_tone_seq #(
    parameter int CLK_DIV        = 1024,
    parameter int TICKS_PER_STEP = 3072,
    parameter int DECAY_DIV      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  wave_sel,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [3:0]  step,
    output logic        note_on
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int DIV_W  = (CLK_DIV > 1)        ? $clog2(CLK_DIV)        : 1;
    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int DEC_W  = (DECAY_DIV > 1)      ? $clog2(DECAY_DIV)      : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_DIV - 1);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] SILENCE   = 16'h8000;

    // Stage-1 pipeline word: waveform value and the envelope it is scaled by.
    typedef struct packed {
        logic [15:0] wave;
        logic [7:0]  env;
    } s1_t;

    // ------------------------------------------------------------------
    // Pattern ROM: bit 7 = rest, [6:4] = octave, [3:0] = semitone
    // ------------------------------------------------------------------
    function automatic logic [7:0] pattern_rom(input logic [3:0] idx);
        logic [7:0] e;
        e = 8'h80;
        case (idx)
            4'h0: e = 8'h40;
            4'h1: e = 8'h44;
            4'h2: e = 8'h47;
            4'h3: e = 8'h50;
            4'h4: e = 8'h80;
            4'h5: e = 8'h47;
            4'h6: e = 8'h44;
            4'h7: e = 8'h40;
            4'h8: e = 8'h35;
            4'h9: e = 8'h39;
            4'hA: e = 8'h40;
            4'hB: e = 8'h45;
            4'hC: e = 8'h80;
            4'hD: e = 8'h42;
            4'hE: e = 8'h47;
            4'hF: e = 8'h4B;
            default: e = 8'h80;
        endcase
        return e;
    endfunction

    // Phase increments for octave 7, C..B; lower octaves are right-shifted.
    function automatic logic [15:0] base_inc(input logic [3:0] semi);
        logic [15:0] b;
        b = 16'd0;
        case (semi)
            4'd0:  b = 16'd5579;
            4'd1:  b = 16'd5911;
            4'd2:  b = 16'd6262;
            4'd3:  b = 16'd6635;
            4'd4:  b = 16'd7029;
            4'd5:  b = 16'd7447;
            4'd6:  b = 16'd7890;
            4'd7:  b = 16'd8359;
            4'd8:  b = 16'd8856;
            4'd9:  b = 16'd9383;
            4'd10: b = 16'd9941;
            4'd11: b = 16'd10532;
            default: b = 16'd0;
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [DEC_W-1:0]  dec_cnt;
    logic [15:0]       phase;
    logic [15:0]       inc;
    logic [15:0]       lfsr;
    logic [7:0]        env;

    s1_t               s1_dat;
    logic              s1_vld;

    // ------------------------------------------------------------------
    // Strobe and step-load decode
    // ------------------------------------------------------------------
    logic strobe;
    logic step_load;

    assign strobe    = enable && (div_cnt == DIV_LAST);
    assign step_load = strobe && (tick_cnt == TICK_LAST);

    // Entry for the step being entered; only meaningful on step_load.
    logic [3:0]  step_nxt;
    logic [7:0]  entry_nxt;
    logic        rest_nxt;
    logic [15:0] inc_nxt;

    assign step_nxt  = step + 4'd1;
    assign entry_nxt = pattern_rom(step_nxt);
    // Semitones 12..15 have no pitch and are played as rests.
    assign rest_nxt  = entry_nxt[7] | (&entry_nxt[3:2]);
    assign inc_nxt   = rest_nxt ? 16'd0
                                : (base_inc(entry_nxt[3:0]) >> (3'd7 - entry_nxt[6:4]));

    // ------------------------------------------------------------------
    // Next oscillator / noise / envelope values for the current strobe.
    // The waveform is built from these post-update values so the stage-1
    // register captures the sample belonging to this strobe.
    // ------------------------------------------------------------------
    logic [15:0] lfsr_nxt;
    logic [15:0] phase_nxt;
    logic [7:0]  env_nxt;
    logic        dec_hit;

    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign dec_hit  = (dec_cnt == DEC_LAST);

    always_comb begin
        phase_nxt = phase + inc;
        env_nxt   = env;
        if (step_load) begin
            // A new step restarts the oscillator and re-triggers (or silences) the envelope.
            phase_nxt = 16'd0;
            env_nxt   = rest_nxt ? 8'd0 : 8'd255;
        end else if (dec_hit && (env != 8'd0)) begin
            env_nxt = env - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Waveform shaping (signed 16-bit result)
    // ------------------------------------------------------------------
    logic [15:0] tri_t;
    logic [15:0] wave_nxt;

    always_comb begin
        tri_t    = phase_nxt[15] ? ~{phase_nxt[14:0], 1'b0} : {phase_nxt[14:0], 1'b0};
        wave_nxt = 16'h0000;
        case (wave_sel)
            2'b00:   wave_nxt = phase_nxt[15] ? 16'h8000 : 16'h7FFF;
            2'b01:   wave_nxt = {~phase_nxt[15], phase_nxt[14:0]};
            2'b10:   wave_nxt = {~tri_t[15], tri_t[14:0]};
            default: wave_nxt = lfsr_nxt;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe divider, sequencer and oscillator state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            tick_cnt <= TICK_LAST;
            dec_cnt  <= '0;
            step     <= 4'hF;
            note_on  <= 1'b0;
            phase    <= 16'd0;
            inc      <= 16'd0;
            lfsr     <= LFSR_SEED;
            env      <= 8'd0;
        end else begin
            if (enable) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
            if (strobe) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
                // The decay divider free-runs over every strobe, step loads included,
                // so decay cadence is not reset by note boundaries.
                dec_cnt  <= dec_hit ? '0 : dec_cnt + DEC_W'(1);
                lfsr     <= lfsr_nxt;
                phase    <= phase_nxt;
                env      <= env_nxt;
                if (step_load) begin
                    step    <= step_nxt;
                    note_on <= !rest_nxt;
                    inc     <= inc_nxt;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture waveform + envelope on the strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= strobe;
            if (strobe) begin
                s1_dat <= '{wave: wave_nxt, env: env_nxt};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed scale by envelope, convert to offset-binary
    // ------------------------------------------------------------------
    logic signed [24:0] wave_x;
    logic signed [24:0] env_x;
    logic signed [24:0] prod;
    logic               unused_prod_bits;

    assign wave_x = 25'($signed(s1_dat.wave));
    assign env_x  = 25'({1'b0, s1_dat.env});
    assign prod   = wave_x * env_x;
    // |wave*env| < 2^23, so bit 23 is the sign and bit 24 only repeats it.
    assign unused_prod_bits = ^{prod[24], prod[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample       <= SILENCE;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            // Muting also drops a sample still in stage 1.
            sample       <= SILENCE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= s1_vld;
            if (s1_vld) begin
                // (prod >>> 8) with the MSB flipped = signed value + 0x8000.
                sample <= {~prod[23], prod[22:8]};
            end
        end
    end

endmodule

// File: tb/tb_audio_tone_seq.sv
module tb_audio_tone_seq;

    localparam int CLK_DIV = 4;
    localparam int TPS     = 4;
    localparam int DDIV    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  wave_sel;
    logic [15:0] sample;
    logic        sample_valid;
    logic [3:0]  step;
    logic        note_on;

    audio_tone_seq #(
        .CLK_DIV        (CLK_DIV),
        .TICKS_PER_STEP (TPS),
        .DECAY_DIV      (DDIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .wave_sel     (wave_sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .step         (step),
        .note_on      (note_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (transaction level, integer arithmetic)
    // ------------------------------------------------------------------
    typedef struct {
        int smp;
        int due;
    } exp_t;

    exp_t sb_q[$];

    int rom[16]      = '{'h40, 'h44, 'h47, 'h50, 'h80, 'h47, 'h44, 'h40,
                         'h35, 'h39, 'h40, 'h45, 'h80, 'h42, 'h47, 'h4B};
    int base_tab[12] = '{5579, 5911, 6262, 6635, 7029, 7447, 7890, 8359,
                         8856, 9383, 9941, 10532};

    int cyc     = 0;
    bit mon_on  = 1'b0;
    int m_div   = 0;
    int m_tick  = TPS - 1;
    int m_step  = 15;
    int m_phase = 0;
    int m_inc   = 0;
    int m_env   = 0;
    int m_dcnt  = 0;
    int m_lfsr  = 'hACE1;
    int m_note  = 0;

    task automatic model_reset();
        m_div = 0; m_tick = TPS - 1; m_step = 15; m_phase = 0; m_inc = 0;
        m_env = 0; m_dcnt = 0; m_lfsr = 'hACE1; m_note = 0;
    endtask

    task automatic model_strobe();
        int e, w, t, p;
        bit rest;
        exp_t x;
        m_lfsr = ((m_lfsr << 1) & 'hFFFF) |
                 (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1);
        m_dcnt = (m_dcnt + 1) % DDIV;
        if (m_tick == TPS - 1) begin
            m_tick  = 0;
            m_step  = (m_step + 1) % 16;
            e       = rom[m_step];
            rest    = (e >= 128) || ((e % 16) >= 12);
            m_note  = rest ? 0 : 1;
            m_env   = rest ? 0 : 255;
            m_inc   = rest ? 0 : (base_tab[e % 16] >> (7 - ((e / 16) % 8)));
            m_phase = 0;
        end else begin
            m_tick  = m_tick + 1;
            m_phase = (m_phase + m_inc) % 65536;
            if (m_dcnt == 0 && m_env > 0) m_env = m_env - 1;
        end
        case (wave_sel)
            2'b00:   w = (m_phase >= 32768) ? -32768 : 32767;
            2'b01:   w = m_phase - 32768;
            2'b10: begin
                t = (m_phase < 32768) ? 2 * m_phase : 65535 - ((2 * m_phase) % 65536);
                w = t - 32768;
            end
            default: w = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
        endcase
        p     = w * m_env;
        x.smp = (p >>> 8) + 32768;
        x.due = cyc + 2;
        sb_q.push_back(x);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
            sb_q.delete();
            cyc    = 0;
            mon_on = 1'b1;
        end else begin
            if (!enable) begin
                // A sample whose output cycle would be the next one is muted.
                if (sb_q.size() > 0 && sb_q[sb_q.size() - 1].due == cyc + 1)
                    sb_q.delete(sb_q.size() - 1);
            end else if (m_div == CLK_DIV - 1) begin
                model_strobe();
            end
            if (enable) m_div = (m_div + 1) % CLK_DIV;
            cyc = cyc + 1;
        end
    end

    // Scoreboard monitor: sampled mid-cycle
    always @(negedge clk) begin
        exp_t h;
        bit exp_vld;
        if (mon_on) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) h = sb_q.pop_front();
            exp_vld = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            chk($sformatf("sb_valid@%0d", cyc), sample_valid, exp_vld);
            if (exp_vld) begin
                h = sb_q.pop_front();
                chk($sformatf("sb_sample@%0d", cyc), sample, h.smp);
            end
            chk($sformatf("sb_step@%0d", cyc), step, m_step);
            chk($sformatf("sb_note_on@%0d", cyc), note_on, m_note);
        end
    end

    // ------------------------------------------------------------------
    // Helpers with bounded waits
    // ------------------------------------------------------------------
    task automatic wait_step(input logic [3:0] s, input int budget);
        int n = 0;
        while (step !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_step_%0h", s), step, s);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < budget);
        chk("valid_seen", sample_valid, 1);
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  ws;
        logic [15:0] smp;
        logic        vld;
        logic [3:0]  stp;
        logic        non;
    } vec_t;

    vec_t vecs[22];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        int n;

        // First note (square) then envelope decay, cycle by cycle from cycle 0.
        vecs[0]  = '{1'b1, 2'b00, 16'h8000, 1'b0, 4'hF, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 16'h8000, 1'b0, 4'hF, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 16'h8000, 1'b0, 4'hF, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 16'h8000, 1'b0, 4'hF, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 16'h8000, 1'b0, 4'h0, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, 16'hFF7F, 1'b1, 4'h0, 1'b1};
        vecs[6]  = '{1'b1, 2'b00, 16'hFF7F, 1'b0, 4'h0, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 16'hFF7F, 1'b0, 4'h0, 1'b1};
        vecs[8]  = '{1'b1, 2'b00, 16'hFF7F, 1'b0, 4'h0, 1'b1};
        vecs[9]  = '{1'b1, 2'b00, 16'hFEFF, 1'b1, 4'h0, 1'b1};
        vecs[10] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[11] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[12] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[13] = '{1'b1, 2'b00, 16'hFEFF, 1'b1, 4'h0, 1'b1};
        vecs[14] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[15] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[16] = '{1'b1, 2'b00, 16'hFEFF, 1'b0, 4'h0, 1'b1};
        vecs[17] = '{1'b1, 2'b00, 16'hFE7F, 1'b1, 4'h0, 1'b1};
        vecs[18] = '{1'b1, 2'b00, 16'hFE7F, 1'b0, 4'h0, 1'b1};
        vecs[19] = '{1'b1, 2'b00, 16'hFE7F, 1'b0, 4'h0, 1'b1};
        vecs[20] = '{1'b1, 2'b00, 16'hFE7F, 1'b0, 4'h1, 1'b1};
        vecs[21] = '{1'b1, 2'b00, 16'hFF7F, 1'b1, 4'h1, 1'b1};

        rst_n    = 1'b0;
        enable   = 1'b1;
        wave_sel = 2'b00;

        // Reset held: outputs at reset values every cycle.
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_sample", sample, 16'h8000);
            chk("rst_valid", sample_valid, 0);
            chk("rst_step", step, 4'hF);
            chk("rst_note_on", note_on, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            enable   = vecs[i].en;
            wave_sel = vecs[i].ws;
            @(negedge clk);
            chk($sformatf("vec%0d_sample", i), sample, vecs[i].smp);
            chk($sformatf("vec%0d_valid", i), sample_valid, vecs[i].vld);
            chk($sformatf("vec%0d_step", i), step, vecs[i].stp);
            chk($sformatf("vec%0d_note_on", i), note_on, vecs[i].non);
            @(posedge clk);
            #1;
        end

        // Rest at step 4, then the step walk with 16-cycle spacing and wrap.
        wait_step(4'h4, 100);
        t_prev = cyc;
        chk("rest_note_on", note_on, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            chk("rest_sample", sample, 16'h8000);
            @(negedge clk);
        end
        for (int k = 5; k <= 17; k++) begin
            wait_step(4'(k % 16), 40);
            chk($sformatf("step_spacing_%0d", k), cyc - t_prev, 16);
            t_prev = cyc;
            if (k == 6)  wave_sel = 2'b01;
            if (k == 8)  wave_sel = 2'b10;
            if (k == 10) wave_sel = 2'b11;
            if (k == 13) wave_sel = 2'b00;
        end

        // Noise from reset.
        @(negedge clk);
        rst_n    = 1'b0;
        wave_sel = 2'b11;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("noise_c4_valid", sample_valid, 0);
        @(negedge clk);
        chk("noise_sample", sample, 16'hD969);
        chk("noise_valid", sample_valid, 1);

        // Enable dropped mid-step 2 for 10 cycles.
        wait_step(4'h2, 100);
        wait_valid(8, n);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dis_sample", sample, 16'h8000);
            chk("dis_valid", sample_valid, 0);
            chk("dis_step", step, 4'h2);
        end
        enable = 1'b1;
        wait_valid(20, n);
        chk("reenable_latency", n, 4);

        // Reset asserted the cycle after a strobe: in-flight sample discarded.
        wait_step(4'h3, 40);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", sample_valid, 0);
        chk("midrst_sample", sample, 16'h8000);
        chk("midrst_step", step, 4'hF);
        chk("midrst_note_on", note_on, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wave_sel = 2'b00;
        repeat (6) @(negedge clk);
        chk("post_rst_sample", sample, 16'hFF7F);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
